// File: rtl/basic_gates_checker.sv
// Stimulus/response checker for the two-input basic-gates block: walks 00,01,10,11,
// compares six gate outputs, counts failing vectors. Optional first-failure log: GATES_CHECK_ERRLOG_EN.
module basic_gates_checker #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       input1,
  output logic       input2,
  input  logic       dut_and,
  input  logic       dut_or,
  input  logic       dut_not,
  input  logic       dut_nand,
  input  logic       dut_nor,
  input  logic       dut_xor,
  output logic       busy,
  output logic       done,
  output logic       pass,
`ifdef GATES_CHECK_ERRLOG_EN
  output logic [1:0] fail_vec,
  output logic [5:0] fail_mask,
`endif
  output logic [2:0] err_count
);

  localparam int NUM_GATES = 6;

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_param
    $error("SETTLE_CYCLES out of range 1..15");
  end

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, FIN} state_t;

  state_t                 state, state_nxt;
  logic [3:0]             cnt;
  logic [1:0]             vec;
  logic [NUM_GATES-1:0]   exp_v, obs, mm;
  logic                   accept, settle_end, last_vec, any_mm;
  logic [2:0]             err_nxt;

  assign input1 = vec[1];
  assign input2 = vec[0];

  // Mask order {xor,nor,nand,not,or,and}; only consumed on the CHECK edge.
  assign exp_v = {vec[1] ^ vec[0], ~(vec[1] | vec[0]), ~(vec[1] & vec[0]),
                  ~vec[1], vec[1] | vec[0], vec[1] & vec[0]};
  assign obs   = {dut_xor, dut_nor, dut_nand, dut_not, dut_or, dut_and};

  for (genvar g = 0; g < NUM_GATES; g++) begin : g_cmp
    assign mm[g] = obs[g] ^ exp_v[g];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SETTLE;
      SETTLE:  if (settle_end) state_nxt = CHECK;
      CHECK:   state_nxt = last_vec ? FIN : SETTLE;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    accept     = (state == IDLE) && start;
    settle_end = (state == SETTLE) && (cnt == 4'(SETTLE_CYCLES - 1));
    last_vec   = (vec == 2'b11);
    any_mm     = |mm;
    err_nxt    = err_count + {2'b00, any_mm};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vec       <= 2'b00;
      cnt       <= 4'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= 3'd0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          vec       <= 2'b00;
          cnt       <= 4'd0;
          err_count <= 3'd0;
          pass      <= 1'b0;
          busy      <= 1'b1;
        end
        SETTLE: if (!settle_end) cnt <= cnt + 4'd1;
        CHECK: begin
          err_count <= err_nxt;
          if (last_vec) begin
            done <= 1'b1;
            pass <= (err_nxt == 3'd0);
          end else begin
            vec <= vec + 2'd1;
            cnt <= 4'd0;
          end
        end
        FIN: begin
          done <= 1'b0;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef GATES_CHECK_ERRLOG_EN
  // err_count still zero on the CHECK edge means this is the first failing vector.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fail_vec  <= 2'b00;
      fail_mask <= 6'b000000;
    end else if (accept) begin
      fail_vec  <= 2'b00;
      fail_mask <= 6'b000000;
    end else if (state == CHECK && any_mm && err_count == 3'd0) begin
      fail_vec  <= vec;
      fail_mask <= mm;
    end
  end
`endif

endmodule

// File: tb/tb_basic_gates_checker.sv
// Directed bench for basic_gates_checker: behavioural gates model with injectable faults.
module tb_basic_gates_checker;

  logic       clk = 1'b0;
  logic       reset, start;
  logic       input1, input2;
  logic       dut_and, dut_or, dut_not, dut_nand, dut_nor, dut_xor;
  logic       busy, done, pass;
  logic [2:0] err_count;
`ifdef GATES_CHECK_ERRLOG_EN
  logic [1:0] fail_vec;
  logic [5:0] fail_mask;
`endif

  int         fault = 0;
  int         n_chk = 0;
  int         n_pass = 0;
  logic [7:0] seq;

  always #5 clk = ~clk;

  basic_gates_checker #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .start(start),
    .input1(input1), .input2(input2),
    .dut_and(dut_and), .dut_or(dut_or), .dut_not(dut_not),
    .dut_nand(dut_nand), .dut_nor(dut_nor), .dut_xor(dut_xor),
    .busy(busy), .done(done), .pass(pass),
`ifdef GATES_CHECK_ERRLOG_EN
    .fail_vec(fail_vec), .fail_mask(fail_mask),
`endif
    .err_count(err_count)
  );

  // Gates block model; fault 1: xor stuck-0, 2: and/or swapped, 3: not and nand both wrong.
  always_comb begin
    dut_and  = input1 & input2;
    dut_or   = input1 | input2;
    dut_not  = ~input1;
    dut_nand = ~(input1 & input2);
    dut_nor  = ~(input1 | input2);
    dut_xor  = input1 ^ input2;
    case (fault)
      1: dut_xor = 1'b0;
      2: begin dut_and = input1 | input2; dut_or = input1 & input2; end
      3: begin dut_not = input1; dut_nand = input1 & input2; end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Start one run; lat = cycle (after the accepting edge) in which done was seen.
  task automatic do_run(input int f, input bit repulse, output int lat);
    int ndone;
    fault = f;
    seq   = 8'h00;
    ndone = 0;
    lat   = -1;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    chk("busy_after_accept", busy, 1);
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      start = repulse && (c == 3 || c == 7);
      @(posedge clk); #1;
      if (c % 3 == 2 && c < 12) seq = {seq[5:0], input1, input2};
      if (done) lat = c;
    end
    start = 1'b0;
    chk("done_seen", int'(lat >= 0), 1);
    // one more cycle: done must drop, busy must drop
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
    chk("busy_drop", busy, 0);
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("no_extra_done", ndone, 0);
    chk("vec_hold", {input1, input2}, 3);
  endtask

  initial begin
    int lat, lowcnt, ndone;
    reset = 1'b1;
    start = 1'b0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_count, 0);
    chk("rst_vec", {input1, input2}, 0);
`ifdef GATES_CHECK_ERRLOG_EN
    chk("rst_fvec", fail_vec, 0);
    chk("rst_fmask", fail_mask, 0);
`endif
    @(negedge clk); reset = 1'b0;

    // golden
    do_run(0, 1'b0, lat);
    chk("gold_lat", lat, 12);
    chk("gold_seq", seq, 8'h1B);
    chk("gold_err", err_count, 0);
    chk("gold_pass", pass, 1);

    // xor stuck-at-0: vectors 01,10 fail
    do_run(1, 1'b0, lat);
    chk("xor_err", err_count, 2);
    chk("xor_pass", pass, 0);
`ifdef GATES_CHECK_ERRLOG_EN
    chk("xor_fvec", fail_vec, 2'b01);
    chk("xor_fmask", fail_mask, 6'b100000);
`endif

    // and/or swapped: vectors 01,10 fail
    do_run(2, 1'b0, lat);
    chk("swap_err", err_count, 2);
    chk("swap_pass", pass, 0);
`ifdef GATES_CHECK_ERRLOG_EN
    chk("swap_fvec", fail_vec, 2'b01);
    chk("swap_fmask", fail_mask, 6'b000011);
`endif

    // two bits wrong on every vector: counted once per vector
    do_run(3, 1'b0, lat);
    chk("multi_err", err_count, 4);
`ifdef GATES_CHECK_ERRLOG_EN
    chk("multi_fvec", fail_vec, 2'b00);
    chk("multi_fmask", fail_mask, 6'b001100);
`endif

    // start re-pulsed mid-run is ignored; also clears previous error state
    do_run(1, 1'b1, lat);
    chk("repulse_lat", lat, 12);
    chk("repulse_err", err_count, 2);

    // reset at cycle 5 of a run
    fault = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int c = 1; c <= 5; c++) begin @(posedge clk); #1; end
    fault = 2;
    reset = 1'b1; #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_vec", {input1, input2}, 0);
    chk("midrst_err", err_count, 0);
    ndone = 0;
    for (int c = 0; c < 3; c++) begin @(posedge clk); #1; if (done) ndone++; end
    chk("midrst_nodone", ndone, 0);
    @(negedge clk); reset = 1'b0;
    do_run(0, 1'b0, lat);
    chk("postrst_lat", lat, 12);
    chk("postrst_pass", pass, 1);

    // start held high: back-to-back runs with one idle cycle between
    fault = 0;
    @(negedge clk); start = 1'b1;
    lat = -1;
    for (int c = 0; c <= 40 && lat < 0; c++) begin @(posedge clk); #1; if (done) lat = c; end
    chk("b2b_first_done", int'(lat >= 0), 1);
    lowcnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (!busy) lowcnt++;
      else if (lowcnt > 0) break;
    end
    chk("b2b_busy_low", lowcnt, 1);
    lat = -1;
    for (int c = 1; c <= 40 && lat < 0; c++) begin @(posedge clk); #1; if (done) lat = c; end
    start = 1'b0;
    chk("b2b_second_lat", lat, 12);
    chk("b2b_pass", pass, 1);
    for (int c = 0; c < 4; c++) begin @(posedge clk); #1; end
    chk("b2b_idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
